// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding and default widths for the CPU run/step controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam int STEP_CNT_W_DEF = 16;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> one-cycle press pulse; 2-flop sync, 2^DEBOUNCE_W hold filter, rise detect.
// Latency 2^DEBOUNCE_W+2 clk from a clean edge; no backpressure, pulses are never held.
module btn_debounce #(
  parameter int DEBOUNCE_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam logic [DEBOUNCE_W-1:0] CNT_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

  logic                  sync1;
  logic                  sync2;
  logic                  stable;
  logic                  stable_d;
  logic [DEBOUNCE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      // Any cycle that agrees with the accepted level restarts the hold window.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (&cnt) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step controller: one-clk cpu_ce per slow-clock rise in RUN, or per debounced step press.
// cpu_ce is registered, 2 clk after a synced mclk rise; no backpressure, excess presses are dropped.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_W = 20,
  parameter int STEP_CNT_W = STEP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mclk_in,
  input  logic                  btn_step,
  input  logic                  btn_run,
  input  logic                  halt_req,
  output logic                  cpu_ce,
  output logic                  run_led,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  localparam logic [STEP_CNT_W-1:0] STEP_ONE = {{(STEP_CNT_W-1){1'b0}}, 1'b1};

  logic   step_press;
  logic   run_press;
  logic   mclk_s1;
  logic   mclk_s2;
  logic   mclk_s2_d;
  logic   tick;
  logic   ce_next;
  state_t state;

  btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_step (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_step),
    .press (step_press)
  );

  btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db_run (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_run),
    .press (run_press)
  );

  // The divided clock is only sampled as data; nothing is clocked by it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mclk_s1   <= 1'b0;
      mclk_s2   <= 1'b0;
      mclk_s2_d <= 1'b0;
    end else begin
      mclk_s1   <= mclk_in;
      mclk_s2   <= mclk_s1;
      mclk_s2_d <= mclk_s2;
    end
  end

  assign tick = mclk_s2 & ~mclk_s2_d;

  // A run press or halt request in RUN suppresses the tick it coincides with.
  assign ce_next = (state == STEP) ||
                   ((state == RUN) && tick && !halt_req && !run_press);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HALT;
      cpu_ce   <= 1'b0;
      step_cnt <= '0;
    end else begin
      cpu_ce <= ce_next;
      if (ce_next) begin
        step_cnt <= step_cnt + STEP_ONE;
      end
      case (state)
        HALT: begin
          if (run_press) begin
            state <= RUN;
          end else if (step_press) begin
            state <= STEP;
          end
        end
        RUN: begin
          if (run_press || halt_req) begin
            state <= HALT;
          end
        end
        STEP:    state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

  assign run_led = (state == RUN);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios plus random buttons/slow clock against a history-window model.
module tb_cpu_step_ctrl;

  localparam int DW  = 4;
  localparam int CW  = 8;
  localparam int WIN = 1 << DW;
  localparam int H   = WIN + 2;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          mclk_in  = 1'b0;
  logic          btn_step = 1'b0;
  logic          btn_run  = 1'b0;
  logic          halt_req = 1'b0;
  logic          cpu_ce;
  logic          run_led;
  logic [CW-1:0] step_cnt;

  always #5 clk = ~clk;

  cpu_step_ctrl #(.DEBOUNCE_W(DW), .STEP_CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .mclk_in  (mclk_in),
    .btn_step (btn_step),
    .btn_run  (btn_run),
    .halt_req (halt_req),
    .cpu_ce   (cpu_ce),
    .run_led  (run_led),
    .step_cnt (step_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: raw input histories (bit i = level seen i edges ago). A button's accepted
  // level flips once its synced value has disagreed for the last 2^DW edges in a row.
  logic [H-1:0] hm = '0;
  logic [H-1:0] hs = '0;
  logic [H-1:0] hr = '0;
  int m_mode = 0;  // 0 halted, 1 running, 2 stepping
  bit m_tick = 0, m_sp = 0, m_rp = 0, m_ce = 0, m_st_s = 0, m_st_r = 0;
  int m_cnt = 0;

  function automatic bit settled_other(input logic [H-1:0] h, input bit st);
    return st ? (h[H-1:2] == '0) : (&h[H-1:2]);
  endfunction

  always @(posedge clk or negedge rst) begin
    bit ce_n;
    if (!rst) begin
      hm = '0; hs = '0; hr = '0;
      m_mode = 0; m_tick = 0; m_sp = 0; m_rp = 0; m_ce = 0;
      m_st_s = 0; m_st_r = 0; m_cnt = 0;
    end else begin
      ce_n = (m_mode == 2) || (m_mode == 1 && m_tick && !halt_req && !m_rp);
      m_ce = ce_n;
      if (ce_n) m_cnt = (m_cnt + 1) % (1 << CW);
      case (m_mode)
        0: if (m_rp) m_mode = 1; else if (m_sp) m_mode = 2;
        1: if (m_rp || halt_req) m_mode = 0;
        default: m_mode = 0;
      endcase
      hm = {hm[H-2:0], mclk_in};
      hs = {hs[H-2:0], btn_step};
      hr = {hr[H-2:0], btn_run};
      m_tick = hm[1] & ~hm[2];
      m_sp = 0;
      if (settled_other(hs, m_st_s)) begin m_st_s = ~m_st_s; m_sp = m_st_s; end
      m_rp = 0;
      if (settled_other(hr, m_st_r)) begin m_st_r = ~m_st_r; m_rp = m_st_r; end
    end
  end

  int cyc = 0, ce_seen = 0, last_ce = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    chk("cpu_ce", cpu_ce, m_ce);
    chk("run_led", run_led, m_mode == 1);
    chk("step_cnt", step_cnt, m_cnt);
    if (cpu_ce) begin
      ce_seen++;
      last_ce = cyc;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_run();
    btn_run = 1'b1;
    wait_cycles(20);
    btn_run = 1'b0;
    wait_cycles(25);
  endtask

  int t0, c0, mh, sh, rh, hh;

  initial begin
    wait_cycles(3);
    #2 rst = 1'b1;
    wait_cycles(10);
    chk("idle_no_ce", ce_seen, 0);

    // single step from HALT
    t0 = ce_seen;
    c0 = cyc + 1;
    btn_step = 1'b1;
    wait_cycles(40);
    btn_step = 1'b0;
    wait_cycles(30);
    chk("step_pulses", ce_seen - t0, 1);
    chk("step_latency", last_ce - c0, WIN + 3);
    chk("step_cnt_after_step", step_cnt, 1);
    chk("step_led", run_led, 0);

    // bouncing button is rejected
    t0 = ce_seen;
    for (int k = 0; k < 5; k++) begin
      btn_step = 1'b1; wait_cycles(10);
      btn_step = 1'b0; wait_cycles(3);
    end
    wait_cycles(30);
    chk("bounce_pulses", ce_seen - t0, 0);
    chk("bounce_cnt", step_cnt, 1);

    // free run: 10 slow-clock periods, step presses ignored
    press_run();
    chk("run_led_on", run_led, 1);
    t0 = ce_seen;
    for (int i = 0; i < 160; i++) begin
      mclk_in  = ((i % 16) < 8);
      btn_step = (i >= 30 && i < 60);
      @(negedge clk);
    end
    wait_cycles(10);
    chk("run_pulses", ce_seen - t0, 10);
    chk("run_cnt", step_cnt, 11);
    chk("run_led_still", run_led, 1);

    // halt_req coincident with tick kills that pulse
    t0 = ce_seen;
    mclk_in = 1'b1;
    wait_cycles(2);
    halt_req = 1'b1;
    wait_cycles(1);
    chk("halt_ce", cpu_ce, 0);
    chk("halt_led", run_led, 0);
    halt_req = 1'b0;
    mclk_in  = 1'b0;
    wait_cycles(5);
    chk("halt_no_pulse", ce_seen - t0, 0);
    btn_step = 1'b1; wait_cycles(25);
    btn_step = 1'b0; wait_cycles(25);
    chk("step_after_halt", ce_seen - t0, 1);

    // persistent halt_req bounces RUN straight back to HALT
    t0 = ce_seen;
    halt_req = 1'b1;
    press_run();
    chk("persist_pulses", ce_seen - t0, 0);
    chk("persist_led", run_led, 0);
    halt_req = 1'b0;

    // asynchronous reset while a pulse is out
    press_run();
    mclk_in = 1'b1;
    wait_cycles(3);
    chk("ce_before_rst", cpu_ce, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_ce", cpu_ce, 0);
    chk("rst_led", run_led, 0);
    chk("rst_cnt", step_cnt, 0);
    mclk_in = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    t0 = ce_seen;
    wait_cycles(20);
    chk("post_rst_quiet", ce_seen - t0, 0);

    // counter wrap
    press_run();
    t0 = ce_seen;
    for (int p = 0; p < (1 << CW) - 1; p++) begin
      mclk_in = 1'b1; wait_cycles(3);
      mclk_in = 1'b0; wait_cycles(3);
    end
    wait_cycles(4);
    chk("pre_wrap_cnt", step_cnt, (1 << CW) - 1);
    mclk_in = 1'b1; wait_cycles(3);
    mclk_in = 1'b0; wait_cycles(5);
    chk("wrap_cnt", step_cnt, 0);
    chk("wrap_pulses", ce_seen - t0, 1 << CW);

    // random buttons, slow clock and halt requests
    mh = 0; sh = 0; rh = 0; hh = 0;
    for (int i = 0; i < 4000; i++) begin
      if (mh == 0) begin mclk_in = ~mclk_in; mh = $urandom_range(8, 3); end else mh--;
      if (sh == 0) begin btn_step = ~btn_step; sh = $urandom_range(40, 1); end else sh--;
      if (rh == 0) begin btn_run = ~btn_run; rh = $urandom_range(60, 1); end else rh--;
      if (hh == 0) begin halt_req = ($urandom_range(3, 0) == 0); hh = $urandom_range(30, 1); end else hh--;
      @(negedge clk);
    end
    mclk_in = 1'b0; btn_step = 1'b0; btn_run = 1'b0; halt_req = 1'b0;
    wait_cycles(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
